// File: rtl/line_fill_buffer.sv
// Line fill buffer: a 16-byte line is filled critical-byte-first from memory, with wrap-around,
// and accepts single-byte store writes whenever a fill is not in progress.
module line_fill_buffer (
    input  logic       clk,
    input  logic       reset,
    input  logic       fill_start,
    input  logic [3:0] start_off,
    input  logic       fill_valid,
    input  logic [7:0] fill_data,
    output logic       fill_ready,
    input  logic       wr_en,
    input  logic [3:0] wr_sel,
    input  logic [7:0] wr_data,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [7:0] out4,
    output logic [7:0] out5,
    output logic [7:0] out6,
    output logic [7:0] out7,
    output logic [7:0] out8,
    output logic [7:0] out9,
    output logic [7:0] out10,
    output logic [7:0] out11,
    output logic [7:0] out12,
    output logic [7:0] out13,
    output logic [7:0] out14,
    output logic [7:0] out15,
    output logic       busy,
    output logic       crit_valid,
    output logic       line_done
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t     state_reg, state_next;
    logic [3:0] ptr_reg;
    logic [3:0] cnt_reg;
    logic [7:0] line_reg [16];
    logic       crit_reg;
    logic       xfer;

    // fill_ready is exactly state==FILL, so a transfer needs only fill_valid in FILL.
    assign xfer = (state_reg == FILL) && fill_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (fill_start) state_next = FILL;
            FILL:    if (xfer && (cnt_reg == 4'd15)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fill_ready = 1'b0;
        busy       = 1'b0;
        line_done  = 1'b0;
        case (state_reg)
            FILL:    begin fill_ready = 1'b1; busy = 1'b1; end
            DONE:    line_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg  <= 4'd0;
            cnt_reg  <= 4'd0;
            crit_reg <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                line_reg[i] <= 8'h00;
            end
        end else begin
            crit_reg <= xfer && (cnt_reg == 4'd0);
            // Stores are blocked during FILL, so they never collide with a fill write.
            if (wr_en && (state_reg != FILL)) begin
                line_reg[wr_sel] <= wr_data;
            end
            if ((state_reg == IDLE) && fill_start) begin
                ptr_reg <= start_off;
                cnt_reg <= 4'd0;
            end
            if (xfer) begin
                line_reg[ptr_reg] <= fill_data;
                ptr_reg           <= ptr_reg + 4'd1;
                cnt_reg           <= cnt_reg + 4'd1;
            end
        end
    end

    assign crit_valid = crit_reg;

    assign out0  = line_reg[0];
    assign out1  = line_reg[1];
    assign out2  = line_reg[2];
    assign out3  = line_reg[3];
    assign out4  = line_reg[4];
    assign out5  = line_reg[5];
    assign out6  = line_reg[6];
    assign out7  = line_reg[7];
    assign out8  = line_reg[8];
    assign out9  = line_reg[9];
    assign out10 = line_reg[10];
    assign out11 = line_reg[11];
    assign out12 = line_reg[12];
    assign out13 = line_reg[13];
    assign out14 = line_reg[14];
    assign out15 = line_reg[15];

endmodule

// File: tb/tb_line_fill_buffer.sv
// Self-checking bench for line_fill_buffer: directed and randomized fills/stores against
// a byte-array model of the line.
module tb_line_fill_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fill_start = 1'b0;
    logic [3:0] start_off = 4'd0;
    logic       fill_valid = 1'b0;
    logic [7:0] fill_data = 8'h00;
    logic       wr_en = 1'b0;
    logic [3:0] wr_sel = 4'd0;
    logic [7:0] wr_data = 8'h00;
    logic       fill_ready, busy, crit_valid, line_done;
    logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0] out8, out9, out10, out11, out12, out13, out14, out15;

    logic [7:0] outv [16];
    logic [7:0] mdl  [16];
    int n_checks = 0;
    int n_fail   = 0;

    line_fill_buffer dut (
        .clk(clk), .reset(reset),
        .fill_start(fill_start), .start_off(start_off),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .out8(out8), .out9(out9), .out10(out10), .out11(out11),
        .out12(out12), .out13(out13), .out14(out14), .out15(out15),
        .busy(busy), .crit_valid(crit_valid), .line_done(line_done)
    );

    always #5 clk = ~clk;

    assign outv[0]  = out0;  assign outv[1]  = out1;  assign outv[2]  = out2;  assign outv[3]  = out3;
    assign outv[4]  = out4;  assign outv[5]  = out5;  assign outv[6]  = out6;  assign outv[7]  = out7;
    assign outv[8]  = out8;  assign outv[9]  = out9;  assign outv[10] = out10; assign outv[11] = out11;
    assign outv[12] = out12; assign outv[13] = out13; assign outv[14] = out14; assign outv[15] = out15;

    // Drives one complete fill. mode 0 = back-to-back, 1 = valid toggles 1/0, 2 = random valid.
    // poke drives fill_start (other offset) and wr_en throughout FILL; both must be ignored.
    task automatic run_fill(input logic [3:0] off, input int mode, input bit rnd,
                            input logic [7:0] base, input bit poke, input bit co_wr,
                            output int cycles);
        int k = 0;
        int cyc = 0;
        bit exp_crit = 0;
        bit v;
        logic [7:0] d;
        logic [3:0] idx;
        @(negedge clk);
        fill_start = 1'b1;
        start_off  = off;
        if (co_wr) begin
            wr_en = 1'b1; wr_sel = 4'd5; wr_data = 8'h5A; mdl[5] = 8'h5A;
        end
        @(negedge clk);
        fill_start = 1'b0;
        wr_en      = 1'b0;
        n_checks++;
        if (fill_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_entry: ready=%b busy=%b, required 1 1", fill_ready, busy);
        end
        if (co_wr) begin
            n_checks++;
            if (outv[5] !== 8'h5A) begin
                n_fail++;
                $display("FAIL co_store: out5=%h, required 5a", outv[5]);
            end
        end
        while (k < 16 && cyc < 200) begin
            n_checks++;
            if (crit_valid !== exp_crit) begin
                n_fail++;
                $display("FAIL crit_valid: cyc=%0d got %b, required %b", cyc, crit_valid, exp_crit);
            end
            if (exp_crit) begin
                n_checks++;
                if (outv[off] !== mdl[off]) begin
                    n_fail++;
                    $display("FAIL crit_byte: out%0d=%h, required %h", off, outv[off], mdl[off]);
                end
            end
            n_checks++;
            if (busy !== 1'b1 || fill_ready !== 1'b1 || line_done !== 1'b0) begin
                n_fail++;
                $display("FAIL in_fill: cyc=%0d busy=%b ready=%b done=%b, required 1 1 0",
                         cyc, busy, fill_ready, line_done);
            end
            exp_crit = 1'b0;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = rnd ? 8'($urandom) : base + 8'(k);
            fill_valid = v;
            fill_data  = d;
            if (poke) begin
                fill_start = 1'b1;
                start_off  = off + 4'($urandom_range(1, 15));
                wr_en      = 1'b1;
                wr_sel     = 4'($urandom);
                wr_data    = 8'($urandom);
            end
            if (v) begin
                idx = off + 4'(k);
                mdl[idx] = d;
                exp_crit = (k == 0);
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        fill_valid = 1'b0;
        fill_start = 1'b0;
        wr_en      = 1'b0;
        cycles     = cyc;
        n_checks++;
        if (k < 16) begin
            n_fail++;
            $display("FAIL fill_timeout: %0d transfers, required 16", k);
        end
        n_checks++;
        if (line_done !== 1'b1 || busy !== 1'b0 || fill_ready !== 1'b0 || crit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_state: done=%b busy=%b ready=%b crit=%b, required 1 0 0 0",
                     line_done, busy, fill_ready, crit_valid);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (outv[i] !== mdl[i]) begin
                n_fail++;
                $display("FAIL line_byte: out%0d=%h, required %h", i, outv[i], mdl[i]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (line_done !== 1'b0 || busy !== 1'b0 || crit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: done=%b busy=%b crit=%b, required 0 0 0",
                     line_done, busy, crit_valid);
        end
        $display("fill off=%0d mode=%0d cycles=%0d", off, mode, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || fill_ready !== 1'b0 || crit_valid !== 1'b0 || line_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b ready=%b crit=%b done=%b, required 0",
                     busy, fill_ready, crit_valid, line_done);
        end
        for (int i = 0; i < 16; i++) begin
            mdl[i] = 8'h00;
            n_checks++;
            if (outv[i] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_byte: out%0d=%h, required 00", i, outv[i]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b, required 0", busy);
        end
        $display("reset done");
    endtask

    task automatic test_aligned();
        int c;
        run_fill(4'd0, 0, 1'b0, 8'h10, 1'b0, 1'b0, c);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (outv[i] !== 8'h10 + 8'(i)) begin
                n_fail++;
                $display("FAIL aligned: out%0d=%h, required %h", i, outv[i], 8'h10 + 8'(i));
            end
        end
        n_checks++;
        if (c != 16) begin
            n_fail++;
            $display("FAIL aligned_cycles: %0d, required 16", c);
        end
    endtask

    task automatic test_wrapped();
        int c;
        run_fill(4'hE, 0, 1'b0, 8'hA0, 1'b0, 1'b0, c);
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (outv[(14 + k) % 16] !== 8'hA0 + 8'(k)) begin
                n_fail++;
                $display("FAIL wrapped: out%0d=%h, required %h", (14 + k) % 16,
                         outv[(14 + k) % 16], 8'hA0 + 8'(k));
            end
        end
    endtask

    task automatic test_throttled();
        int c;
        run_fill(4'(7), 1, 1'b0, 8'h60, 1'b0, 1'b0, c);
        n_checks++;
        if (c != 31) begin
            n_fail++;
            $display("FAIL throttle_cycles: %0d, required 31", c);
        end
    endtask

    task automatic test_store();
        int c;
        logic [3:0] s;
        @(negedge clk);
        wr_en = 1'b1; wr_sel = 4'd5; wr_data = 8'h5A; mdl[5] = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++;
        if (out5 !== 8'h5A) begin
            n_fail++;
            $display("FAIL store5: out5=%h, required 5a", out5);
        end
        for (int n = 0; n < 6; n++) begin
            s = 4'($urandom);
            wr_en = 1'b1; wr_sel = s; wr_data = 8'($urandom); mdl[s] = wr_data;
            @(negedge clk);
            wr_en = 1'b0;
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (outv[i] !== mdl[i]) begin
                    n_fail++;
                    $display("FAIL store_idle: sel=%0d out%0d=%h, required %h", s, i, outv[i], mdl[i]);
                end
            end
            $display("store sel=%0d data=%h", s, mdl[s]);
        end
        // Stores during FILL are dropped; a store coinciding with fill_start lands first.
        run_fill(4'd2, 0, 1'b1, 8'h00, 1'b1, 1'b0, c);
        run_fill(4'd1, 0, 1'b0, 8'hC0, 1'b0, 1'b1, c);
    endtask

    task automatic test_reset_mid_fill();
        int c;
        int nx;
        logic [3:0] off;
        for (int pass = 0; pass < 2; pass++) begin
            nx  = (pass == 0) ? 7 : 1;
            off = 4'($urandom);
            @(negedge clk);
            fill_start = 1'b1; start_off = off;
            @(negedge clk);
            fill_start = 1'b0;
            repeat (nx) begin
                fill_valid = 1'b1; fill_data = 8'($urandom) | 8'h01;
                @(negedge clk);
            end
            #1 reset = 1'b1;
            #1;
            n_checks++;
            if (busy !== 1'b0 || fill_ready !== 1'b0 || crit_valid !== 1'b0 || line_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_flags: busy=%b ready=%b crit=%b done=%b, required 0",
                         busy, fill_ready, crit_valid, line_done);
            end
            for (int i = 0; i < 16; i++) begin
                mdl[i] = 8'h00;
                n_checks++;
                if (outv[i] !== 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_mid_byte: out%0d=%h, required 00", i, outv[i]);
                end
            end
            @(negedge clk);
            reset = 1'b0;
            fill_valid = 1'b0;
            repeat (3) begin
                @(negedge clk);
                n_checks++;
                if (line_done !== 1'b0 || crit_valid !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_abort: done=%b crit=%b busy=%b, required 0 0 0",
                             line_done, crit_valid, busy);
                end
            end
            $display("reset mid-fill after %0d transfers", nx);
        end
        run_fill(4'($urandom), 0, 1'b1, 8'h00, 1'b0, 1'b0, c);
    endtask

    task automatic test_start_during_fill();
        int c;
        run_fill(4'd3, 0, 1'b0, 8'h40, 1'b1, 1'b0, c);
        run_fill(4'd9, 1, 1'b0, 8'h80, 1'b1, 1'b0, c);
    endtask

    task automatic test_random();
        int c;
        logic [3:0] s;
        for (int it = 0; it < 4; it++) begin
            repeat (2) begin
                @(negedge clk);
                s = 4'($urandom);
                wr_en = 1'b1; wr_sel = s; wr_data = 8'($urandom); mdl[s] = wr_data;
                @(negedge clk);
                wr_en = 1'b0;
                n_checks++;
                if (outv[s] !== mdl[s]) begin
                    n_fail++;
                    $display("FAIL rand_store: out%0d=%h, required %h", s, outv[s], mdl[s]);
                end
            end
            run_fill(4'($urandom), 2, 1'b1, 8'h00, 1'($urandom_range(0, 1)), 1'b0, c);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_wrapped();
        test_throttled();
        test_store();
        test_reset_mid_fill();
        test_start_during_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
